piso_shift_tx: RTL

Parallel-in / serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, LSB first, with framing strobes. It is the sending end of the single-bit serial path whose receive side is a chain of rising-edge D flip-flops sampling `sout` on `clk`. It sits between a word-level producer and that bit-level capture logic.

---
 rtl/piso_shift_tx_pkg.sv | 11 +
 rtl/piso_bit_counter.sv | 29 ++
 rtl/piso_shift_tx.sv | 96 +++++++++
 3 files changed

// File: rtl/piso_shift_tx_pkg.sv
// Shared definitions for the serial transmit path (transmitter and matching receiver).
package piso_shift_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  localparam int PISO_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter holding the number of frame bits left after the one on the line.
module piso_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] cnt;

  // A load wins over a decrement so a back-to-back reload restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(WIDTH - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in / serial-out transmitter: accepts a word on valid/ready and sends it LSB first.
//
// state | meaning
// IDLE  | no frame in flight; line parked at 0, ready for a word
// SHIFT | frame bit on sout; ready again once the last bit is on the line
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  piso_state_e      state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             sout_nxt, sout_valid_nxt, frame_start_nxt, done_nxt;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             accept;

  piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  assign load_ready = (state == IDLE) || ((state == SHIFT) && cnt_zero);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_nxt       = state;
    sreg_nxt        = sreg;
    sout_nxt        = 1'b0;
    sout_valid_nxt  = 1'b0;
    frame_start_nxt = 1'b0;
    done_nxt        = 1'b0;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;

    if (accept) begin
      // A reload on the last bit keeps the line busy and still reports the finished word.
      state_nxt       = SHIFT;
      sreg_nxt        = load_data >> 1;
      sout_nxt        = load_data[0];
      sout_valid_nxt  = 1'b1;
      frame_start_nxt = 1'b1;
      done_nxt        = (state == SHIFT);
      cnt_load        = 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (!cnt_zero) begin
            sreg_nxt       = sreg >> 1;
            sout_nxt       = sreg[0];
            sout_valid_nxt = 1'b1;
            cnt_dec        = 1'b1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sreg        <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      sreg        <= sreg_nxt;
      sout        <= sout_nxt;
      sout_valid  <= sout_valid_nxt;
      frame_start <= frame_start_nxt;
      done        <= done_nxt;
    end
  end

endmodule
